tx_code_group: RTL and testbench
================================

Name: tx_code_group

Overview:
- 1000BASE-X PCS transmit code-group generator (Clause 36 transmit code-group function).
- Consumes the ordered-set request tx_o_set and TXD from the transmit ordered-set machine.
- Emits one 8-bit code-group plus K flag per GTX_CLK cycle to the 8b/10b encoder.
- Generates tx_even and the tx_oset_indicate accept strobe back to the ordered-set machine.

Parameters:
- PAD_MISALIGNED, 1, 1 = pad an odd-aligned /I/ or /C/ request with one /R/; 0 = start it immediately (alignment violation tolerated).

Ports:
- clk  in  1  125 MHz GTX_CLK.
- reset  in  1  Synchronous, active-high.
- tx_o_set  in  3  Requested ordered set: 0=/C/, 1=/I/, 2=/S/, 3=/V/, 4=/T/, 5=/R/, 6=/D/; 7 is treated as /V/.
- txd  in  8  Data octet for /D/.
- tx_config_reg  in  16  Autoneg config word for /C/.
- tx_rd_pos  in  1  Encoder running disparity after the previous code-group; 1 = positive.
- tx_code_group  out  8  Octet to encoder.
- tx_is_k  out  1  1 = special (K) code-group.
- tx_even  out  1  1 = current code-group is at an even position.
- tx_oset_indicate  out  1  Current code-group ends the current set; tx_o_set/txd are accepted at this cycle's closing edge.

Behaviour:
- Output register:
  - All outputs are registered.
  - tx_even toggles every cycle, except that reset forces it.
- Accept handshake:
  - tx_o_set, txd, tx_config_reg and tx_rd_pos are sampled only at an edge closing a cycle with tx_oset_indicate=1.
  - The upstream block must advance its state at that same edge.
  - The first code-group of the accepted set appears in the next cycle.
- Reset:
  - The edge with reset=1 loads state TAIL.
  - TAIL outputs: tx_code_group=0x50, tx_is_k=0, tx_even=0, tx_oset_indicate=1.
  - The C1/C2 toggle clears so the next /C/ is /C1/.
  - Reset mid-set aborts the set at the next edge.
- States and outputs:
  - TAIL: behaves as the final code-group of a set.
  - SPECIAL_GO: one cycle, K=1, indicate=1. Codes: /S/ 0xFB, /T/ 0xFD, /R/ 0xF7, /V/ 0xFE.
  - DATA_GO: one cycle, code = accepted txd, K=0, indicate=1.
  - IDLE_K, then IDLE_D:
    - IDLE_K outputs 0xBC with K=1.
    - IDLE_D outputs D5.6 0xC5 if tx_rd_pos was 1 at accept (/I1/), else D16.2 0x50 (/I2/); K=0, indicate=1.
  - CFG_K, CFG_D, CFG_LO, CFG_HI:
    - CFG_K outputs 0xBC with K=1.
    - CFG_D outputs D21.5 0xB5 for /C1/ or D2.2 0x42 for /C2/.
    - CFG_LO outputs tx_config_reg[7:0]; CFG_HI outputs tx_config_reg[15:8] with indicate=1.
    - The toggle flips after each /C/.
    - The toggle resets to C1 when any non-/C/ set is accepted.
    - The config word is held internally for the whole set.
  - ALIGN_PAD:
    - Entered when /I/ or /C/ is accepted while the current tx_even=1 (next slot would be odd) and PAD_MISALIGNED=1.
    - Outputs /R/ 0xF7, K=1, indicate=0.
    - The pending request is held internally and its first code-group follows on the even slot.
- Transitions: from any indicate=1 state, the accepted tx_o_set selects SPECIAL_GO, DATA_GO, IDLE_K, CFG_K or ALIGN_PAD.
- Throughput:
  - Back-to-back /D/ gives continuous one-octet-per-cycle output, indicate held high.
  - /I/ takes 2 cycles, /C/ takes 4.
- Disparity: tx_rd_pos is sampled at accept only; later changes within the set are ignored.

Decomposition:
- Shared package pcs_tx_pkg:
  - tx_o_set encodings (OS_C..OS_D).
  - Code-group constants: K28_5=0xBC, K27_7=0xFB, K29_7=0xFD, K23_7=0xF7, K30_7=0xFE, D5_6=0xC5, D16_2=0x50, D21_5=0xB5, D2_2=0x42.
  - State enumeration for this block.
- No sub-module; a single FSM plus output register.

Test Plan:
- Reset then tx_o_set=1 with tx_rd_pos=0 held -> BC(K,even), 50, BC, 50 ...; indicate high on every 0x50; tx_even 1,0,1,0.
- tx_o_set=1 with tx_rd_pos=1 at accept -> BC then C5; a tx_rd_pos change mid-set has no effect.
- Idle, then /S/, then /D/ 0x11,0x22,0x33, then /T/, /R/, /R/, /I/ -> FB, 11, 22, 33, FD, F7, F7, BC, 50; indicate continuous through the data.
- Repeated /C/ with tx_config_reg=0x41A0 -> BC,B5,A0,41,BC,42,A0,41; indicate only on the 0x41 bytes.
- /D/ then /I/ accepted at an even position -> one F7 with indicate=0, then BC on tx_even=1; with PAD_MISALIGNED=0 -> BC on the odd slot.
- Reset asserted during CFG_LO -> the next cycle shows TAIL outputs (50, even=0, indicate=1); a following /C/ emits B5 (C1).

Source files
------------

// File: rtl/pcs_tx_pkg.sv
// rtl/pcs_tx_pkg.sv - shared 1000BASE-X PCS transmit encodings and state types
package pcs_tx_pkg;

  localparam logic [2:0] OS_C = 3'd0;
  localparam logic [2:0] OS_I = 3'd1;
  localparam logic [2:0] OS_S = 3'd2;
  localparam logic [2:0] OS_V = 3'd3;
  localparam logic [2:0] OS_T = 3'd4;
  localparam logic [2:0] OS_R = 3'd5;
  localparam logic [2:0] OS_D = 3'd6;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;

  typedef enum logic [3:0] {
    ST_TAIL,
    ST_SPECIAL_GO,
    ST_DATA_GO,
    ST_IDLE_K,
    ST_IDLE_D,
    ST_CFG_K,
    ST_CFG_D,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_ALIGN_PAD
  } tx_cg_state_e;

  // Single-code-group sets; the reserved encoding 7 falls through to /V/.
  function automatic logic [7:0] special_code(input logic [2:0] os);
    case (os)
      OS_S:    return K27_7;
      OS_T:    return K29_7;
      OS_R:    return K23_7;
      default: return K30_7;
    endcase
  endfunction

endpackage

// File: rtl/tx_code_group_if.sv
// rtl/tx_code_group_if.sv - ordered-set request in, code-group out
interface tx_code_group_if;
  logic [2:0]  tx_o_set;
  logic [7:0]  txd;
  logic [15:0] tx_config_reg;
  logic        tx_rd_pos;
  logic [7:0]  tx_code_group;
  logic        tx_is_k;
  logic        tx_even;
  logic        tx_oset_indicate;

  modport master (
    output tx_o_set, txd, tx_config_reg, tx_rd_pos,
    input  tx_code_group, tx_is_k, tx_even, tx_oset_indicate
  );

  modport slave (
    input  tx_o_set, txd, tx_config_reg, tx_rd_pos,
    output tx_code_group, tx_is_k, tx_even, tx_oset_indicate
  );
endinterface

// File: rtl/tx_code_group.sv
// rtl/tx_code_group.sv - PCS transmit code-group generator with registered outputs
module tx_code_group
  import pcs_tx_pkg::*;
#(
  parameter bit PAD_MISALIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  tx_code_group_if.slave   cg
);

  tx_cg_state_e state_q, state_d;
  logic [7:0]   code_q, code_d;
  logic         is_k_q, is_k_d;
  logic         ind_q, ind_d;
  logic         even_q;
  logic         c2_q, c2_d;
  logic [15:0]  cfg_q, cfg_d;
  logic         rd_q, rd_d;
  logic         pend_cfg_q, pend_cfg_d;
  logic         pad_now;

  // A two- or four-group set must start on an even slot; the slot after this one is odd when even_q=1.
  assign pad_now = PAD_MISALIGNED && even_q;

  always_comb begin
    state_d    = state_q;
    c2_d       = c2_q;
    cfg_d      = cfg_q;
    rd_d       = rd_q;
    pend_cfg_d = pend_cfg_q;
    if (ind_q) begin
      case (cg.tx_o_set)
        OS_C: begin
          cfg_d      = cg.tx_config_reg;
          pend_cfg_d = 1'b1;
          state_d    = pad_now ? ST_ALIGN_PAD : ST_CFG_K;
        end
        OS_I: begin
          rd_d       = cg.tx_rd_pos;
          c2_d       = 1'b0;
          pend_cfg_d = 1'b0;
          state_d    = pad_now ? ST_ALIGN_PAD : ST_IDLE_K;
        end
        OS_D: begin
          c2_d    = 1'b0;
          state_d = ST_DATA_GO;
        end
        default: begin
          c2_d    = 1'b0;
          state_d = ST_SPECIAL_GO;
        end
      endcase
    end else begin
      case (state_q)
        ST_IDLE_K:    state_d = ST_IDLE_D;
        ST_CFG_K: begin
          state_d = ST_CFG_D;
          c2_d    = ~c2_q;
        end
        ST_CFG_D:     state_d = ST_CFG_LO;
        ST_CFG_LO:    state_d = ST_CFG_HI;
        ST_ALIGN_PAD: state_d = pend_cfg_q ? ST_CFG_K : ST_IDLE_K;
        default:      state_d = ST_TAIL;
      endcase
    end

    code_d = D16_2;
    is_k_d = 1'b0;
    ind_d  = 1'b1;
    case (state_d)
      ST_SPECIAL_GO: begin
        code_d = special_code(cg.tx_o_set);
        is_k_d = 1'b1;
      end
      ST_DATA_GO:    code_d = cg.txd;
      ST_IDLE_K, ST_CFG_K: begin
        code_d = K28_5;
        is_k_d = 1'b1;
        ind_d  = 1'b0;
      end
      ST_IDLE_D:     code_d = rd_q ? D5_6 : D16_2;
      ST_CFG_D: begin
        code_d = c2_q ? D2_2 : D21_5;
        ind_d  = 1'b0;
      end
      ST_CFG_LO: begin
        code_d = cfg_q[7:0];
        ind_d  = 1'b0;
      end
      ST_CFG_HI:     code_d = cfg_q[15:8];
      ST_ALIGN_PAD: begin
        code_d = K23_7;
        is_k_d = 1'b1;
        ind_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_TAIL;
      code_q     <= D16_2;
      is_k_q     <= 1'b0;
      ind_q      <= 1'b1;
      even_q     <= 1'b0;
      c2_q       <= 1'b0;
      cfg_q      <= '0;
      rd_q       <= 1'b0;
      pend_cfg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      is_k_q     <= is_k_d;
      ind_q      <= ind_d;
      even_q     <= ~even_q;
      c2_q       <= c2_d;
      cfg_q      <= cfg_d;
      rd_q       <= rd_d;
      pend_cfg_q <= pend_cfg_d;
    end
  end

  assign cg.tx_code_group    = code_q;
  assign cg.tx_is_k          = is_k_q;
  assign cg.tx_even          = even_q;
  assign cg.tx_oset_indicate = ind_q;

endmodule

// File: tb/tb_tx_code_group.sv
// tb/tb_tx_code_group.sv - self-checking bench for tx_code_group (padding on and off)
module tb_tx_code_group;

  typedef struct packed {
    logic [7:0] code;
    logic       k;
    logic       ind;
    logic       even;
  } obs_t;

  typedef struct packed {
    logic [7:0] code;
    logic       k;
    logic       ind;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #4 clk = ~clk;

  tx_code_group_if if0 ();
  tx_code_group_if if1 ();

  tx_code_group #(.PAD_MISALIGNED(1'b1)) dut0 (.clk(clk), .reset(reset), .cg(if0.slave));
  tx_code_group #(.PAD_MISALIGNED(1'b0)) dut1 (.clk(clk), .reset(reset), .cg(if1.slave));

  function automatic obs_t get0();
    return {if0.tx_code_group, if0.tx_is_k, if0.tx_oset_indicate, if0.tx_even};
  endfunction

  function automatic obs_t get1();
    return {if1.tx_code_group, if1.tx_is_k, if1.tx_oset_indicate, if1.tx_even};
  endfunction

  task automatic tick(input logic [2:0] os, input logic [7:0] d, input logic [15:0] cfg,
                      input logic rd, input logic rst);
    reset = rst;
    if0.tx_o_set = os; if0.txd = d; if0.tx_config_reg = cfg; if0.tx_rd_pos = rd;
    if1.tx_o_set = os; if1.txd = d; if1.tx_config_reg = cfg; if1.tx_rd_pos = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: the full code-group sequence of one accepted ordered set.
  function automatic int expand(input bit pad, input bit even_now, inout bit c2,
                                input logic [2:0] os, input logic [7:0] d,
                                input logic [15:0] cfg, input logic rd, output ent_t seq[5]);
    int n = 0;
    if ((os == 3'd0 || os == 3'd1) && pad && even_now) begin
      seq[n] = {8'hF7, 1'b1, 1'b0}; n++;
    end
    case (os)
      3'd0: begin
        seq[n] = {8'hBC, 1'b1, 1'b0}; n++;
        seq[n] = {(c2 ? 8'h42 : 8'hB5), 1'b0, 1'b0}; n++;
        seq[n] = {cfg[7:0], 1'b0, 1'b0}; n++;
        seq[n] = {cfg[15:8], 1'b0, 1'b1}; n++;
        c2 = ~c2;
      end
      3'd1: begin
        seq[n] = {8'hBC, 1'b1, 1'b0}; n++;
        seq[n] = {(rd ? 8'hC5 : 8'h50), 1'b0, 1'b1}; n++;
        c2 = 1'b0;
      end
      3'd2: begin seq[n] = {8'hFB, 1'b1, 1'b1}; n++; c2 = 1'b0; end
      3'd4: begin seq[n] = {8'hFD, 1'b1, 1'b1}; n++; c2 = 1'b0; end
      3'd5: begin seq[n] = {8'hF7, 1'b1, 1'b1}; n++; c2 = 1'b0; end
      3'd6: begin seq[n] = {d, 1'b0, 1'b1}; n++; c2 = 1'b0; end
      default: begin seq[n] = {8'hFE, 1'b1, 1'b1}; n++; c2 = 1'b0; end
    endcase
    return n;
  endfunction

  task automatic test_reset();
    obs_t o0, o1;
    obs_t e = {8'h50, 1'b0, 1'b1, 1'b0};
    tick(3'd1, 8'h00, 16'h0, 1'b0, 1'b1);
    o0 = get0(); o1 = get1();
    checks++;
    if (o0 !== e) begin
      errors++;
      $display("FAIL reset dut0: got %h/%b/%b/%b want %h/%b/%b/%b",
               o0.code, o0.k, o0.ind, o0.even, e.code, e.k, e.ind, e.even);
    end
    checks++;
    if (o1 !== e) begin
      errors++;
      $display("FAIL reset dut1: got %h/%b/%b/%b want %h/%b/%b/%b",
               o1.code, o1.k, o1.ind, o1.even, e.code, e.k, e.ind, e.even);
    end
  endtask

  task automatic test_idle();
    obs_t o0, o1;
    obs_t exp_t [4] = '{{8'hBC, 1'b1, 1'b0, 1'b1}, {8'h50, 1'b0, 1'b1, 1'b0},
                        {8'hBC, 1'b1, 1'b0, 1'b1}, {8'h50, 1'b0, 1'b1, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      tick(3'd1, 8'h00, 16'h0, 1'b0, 1'b0);
      o0 = get0(); o1 = get1();
      checks++;
      if (o0 !== exp_t[i] || o1 !== exp_t[i]) begin
        errors++;
        $display("FAIL idle[%0d]: got %h/%b/%b/%b and %h/%b/%b/%b want %h/%b/%b/%b", i,
                 o0.code, o0.k, o0.ind, o0.even, o1.code, o1.k, o1.ind, o1.even,
                 exp_t[i].code, exp_t[i].k, exp_t[i].ind, exp_t[i].even);
      end
    end
  endtask

  task automatic test_idle_rd();
    obs_t o0, o1;
    logic rd_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    obs_t exp_t [4] = '{{8'hBC, 1'b1, 1'b0, 1'b1}, {8'hC5, 1'b0, 1'b1, 1'b0},
                        {8'hBC, 1'b1, 1'b0, 1'b1}, {8'h50, 1'b0, 1'b1, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      tick(3'd1, 8'h00, 16'h0, rd_t[i], 1'b0);
      o0 = get0(); o1 = get1();
      checks++;
      if (o0 !== exp_t[i] || o1 !== exp_t[i]) begin
        errors++;
        $display("FAIL idle_rd[%0d]: got %h/%b/%b/%b and %h/%b/%b/%b want %h/%b/%b/%b", i,
                 o0.code, o0.k, o0.ind, o0.even, o1.code, o1.k, o1.ind, o1.even,
                 exp_t[i].code, exp_t[i].k, exp_t[i].ind, exp_t[i].even);
      end
    end
  endtask

  task automatic test_data_stream();
    obs_t o0, o1;
    logic [2:0] os_t [10] = '{3'd6, 3'd2, 3'd6, 3'd6, 3'd6, 3'd4, 3'd5, 3'd5, 3'd1, 3'd1};
    logic [7:0] d_t  [10] = '{8'h99, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    obs_t exp_t [10] = '{{8'h99, 1'b0, 1'b1, 1'b1}, {8'hFB, 1'b1, 1'b1, 1'b0},
                         {8'h11, 1'b0, 1'b1, 1'b1}, {8'h22, 1'b0, 1'b1, 1'b0},
                         {8'h33, 1'b0, 1'b1, 1'b1}, {8'hFD, 1'b1, 1'b1, 1'b0},
                         {8'hF7, 1'b1, 1'b1, 1'b1}, {8'hF7, 1'b1, 1'b1, 1'b0},
                         {8'hBC, 1'b1, 1'b0, 1'b1}, {8'h50, 1'b0, 1'b1, 1'b0}};
    tick(3'd1, 8'h00, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(os_t[i], d_t[i], 16'h0, 1'b0, 1'b0);
      o0 = get0(); o1 = get1();
      checks++;
      if (o0 !== exp_t[i] || o1 !== exp_t[i]) begin
        errors++;
        $display("FAIL data_stream[%0d]: got %h/%b/%b/%b and %h/%b/%b/%b want %h/%b/%b/%b", i,
                 o0.code, o0.k, o0.ind, o0.even, o1.code, o1.k, o1.ind, o1.even,
                 exp_t[i].code, exp_t[i].k, exp_t[i].ind, exp_t[i].even);
      end
    end
  endtask

  task automatic test_config();
    obs_t o0, o1;
    obs_t exp_t [8] = '{{8'hBC, 1'b1, 1'b0, 1'b1}, {8'hB5, 1'b0, 1'b0, 1'b0},
                        {8'hA0, 1'b0, 1'b0, 1'b1}, {8'h41, 1'b0, 1'b1, 1'b0},
                        {8'hBC, 1'b1, 1'b0, 1'b1}, {8'h42, 1'b0, 1'b0, 1'b0},
                        {8'hA0, 1'b0, 1'b0, 1'b1}, {8'h41, 1'b0, 1'b1, 1'b0}};
    tick(3'd1, 8'h00, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(3'd0, 8'h00, 16'h41A0, 1'($urandom_range(0, 1)), 1'b0);
      o0 = get0(); o1 = get1();
      checks++;
      if (o0 !== exp_t[i] || o1 !== exp_t[i]) begin
        errors++;
        $display("FAIL config[%0d]: got %h/%b/%b/%b and %h/%b/%b/%b want %h/%b/%b/%b", i,
                 o0.code, o0.k, o0.ind, o0.even, o1.code, o1.k, o1.ind, o1.even,
                 exp_t[i].code, exp_t[i].k, exp_t[i].ind, exp_t[i].even);
      end
    end
  endtask

  task automatic test_pad();
    obs_t o0, o1;
    obs_t e0 [4] = '{{8'h5A, 1'b0, 1'b1, 1'b1}, {8'hF7, 1'b1, 1'b0, 1'b0},
                     {8'hBC, 1'b1, 1'b0, 1'b1}, {8'h50, 1'b0, 1'b1, 1'b0}};
    obs_t e1 [4] = '{{8'h5A, 1'b0, 1'b1, 1'b1}, {8'hBC, 1'b1, 1'b0, 1'b0},
                     {8'h50, 1'b0, 1'b1, 1'b1}, {8'hBC, 1'b1, 1'b0, 1'b0}};
    tick(3'd1, 8'h00, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick((i == 0) ? 3'd6 : 3'd1, 8'h5A, 16'h0, 1'b0, 1'b0);
      o0 = get0(); o1 = get1();
      checks++;
      if (o0 !== e0[i]) begin
        errors++;
        $display("FAIL pad_on[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 o0.code, o0.k, o0.ind, o0.even, e0[i].code, e0[i].k, e0[i].ind, e0[i].even);
      end
      checks++;
      if (o1 !== e1[i]) begin
        errors++;
        $display("FAIL pad_off[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                 o1.code, o1.k, o1.ind, o1.even, e1[i].code, e1[i].k, e1[i].ind, e1[i].even);
      end
    end
  endtask

  task automatic test_reset_mid_cfg();
    obs_t o0, o1;
    logic rst_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    obs_t exp_t [6] = '{{8'hBC, 1'b1, 1'b0, 1'b1}, {8'hB5, 1'b0, 1'b0, 1'b0},
                        {8'hA0, 1'b0, 1'b0, 1'b1}, {8'h50, 1'b0, 1'b1, 1'b0},
                        {8'hBC, 1'b1, 1'b0, 1'b1}, {8'hB5, 1'b0, 1'b0, 1'b0}};
    tick(3'd1, 8'h00, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(3'd0, 8'h00, 16'h41A0, 1'b0, rst_t[i]);
      o0 = get0(); o1 = get1();
      checks++;
      if (o0 !== exp_t[i] || o1 !== exp_t[i]) begin
        errors++;
        $display("FAIL reset_mid_cfg[%0d]: got %h/%b/%b/%b and %h/%b/%b/%b want %h/%b/%b/%b", i,
                 o0.code, o0.k, o0.ind, o0.even, o1.code, o1.k, o1.ind, o1.even,
                 exp_t[i].code, exp_t[i].k, exp_t[i].ind, exp_t[i].even);
      end
    end
  endtask

  task automatic test_random();
    ent_t q0[$], q1[$];
    ent_t seq[5];
    ent_t cur;
    bit c2_0 = 1'b0, c2_1 = 1'b0, ev0 = 1'b0, ev1 = 1'b0;
    int n;
    obs_t o0, o1, e0, e1;
    logic [2:0] os; logic [7:0] d; logic [15:0] cfg; logic rd, rst;
    tick(3'd1, 8'h00, 16'h0, 1'b0, 1'b1);
    q0.push_back({8'h50, 1'b0, 1'b1});
    q1.push_back({8'h50, 1'b0, 1'b1});
    for (int cyc = 0; cyc < 800; cyc++) begin
      os  = 3'($urandom_range(0, 7));
      d   = 8'($urandom);
      cfg = 16'($urandom);
      rd  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 99) == 0);
      cur = q0.pop_front();
      if (rst) begin
        q0.delete(); q0.push_back({8'h50, 1'b0, 1'b1}); c2_0 = 1'b0; ev0 = 1'b0;
      end else begin
        if (cur.ind) begin
          n = expand(1'b1, ev0, c2_0, os, d, cfg, rd, seq);
          for (int j = 0; j < n; j++) q0.push_back(seq[j]);
        end
        ev0 = ~ev0;
      end
      cur = q1.pop_front();
      if (rst) begin
        q1.delete(); q1.push_back({8'h50, 1'b0, 1'b1}); c2_1 = 1'b0; ev1 = 1'b0;
      end else begin
        if (cur.ind) begin
          n = expand(1'b0, ev1, c2_1, os, d, cfg, rd, seq);
          for (int j = 0; j < n; j++) q1.push_back(seq[j]);
        end
        ev1 = ~ev1;
      end
      tick(os, d, cfg, rd, rst);
      o0 = get0(); o1 = get1();
      e0 = {q0[0], ev0};
      e1 = {q1[0], ev1};
      checks++;
      if (o0 !== e0) begin
        errors++;
        $display("FAIL random dut0 cyc %0d: got %h/%b/%b/%b want %h/%b/%b/%b", cyc,
                 o0.code, o0.k, o0.ind, o0.even, e0.code, e0.k, e0.ind, e0.even);
      end
      checks++;
      if (o1 !== e1) begin
        errors++;
        $display("FAIL random dut1 cyc %0d: got %h/%b/%b/%b want %h/%b/%b/%b", cyc,
                 o1.code, o1.k, o1.ind, o1.even, e1.code, e1.k, e1.ind, e1.even);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    if0.tx_o_set = 3'd1; if0.txd = 8'h00; if0.tx_config_reg = 16'h0; if0.tx_rd_pos = 1'b0;
    if1.tx_o_set = 3'd1; if1.txd = 8'h00; if1.tx_config_reg = 16'h0; if1.tx_rd_pos = 1'b0;
    test_reset();
    test_idle();
    test_idle_rd();
    test_data_stream();
    test_config();
    test_pad();
    test_reset_mid_cfg();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
